// File: rtl/imem_responder.sv
// Instruction-memory responder: word-organised synchronous memory serving
// IREQn/IADDR fetches after a fixed wait-state count, with a preload port.
module imem_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int CW      = 4
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          IREQn,
  input  logic [31:0]   IADDR,
  output logic [31:0]   IDBUS,
  output logic          IRDY,
  output logic          IERR,
  output logic          BUSY,
  input  logic          LDEN,
  input  logic [AW-1:0] LDADDR,
  input  logic [31:0]   LDDATA
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic          oor_q;
  logic [31:0]   mem [2**AW];

  // Byte-lane bits of the fetch address carry no information for word fetches.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, IADDR[1:0]};

  // Array write port: preload is honoured in any state; no reset on contents.
  always_ff @(posedge CLK) begin
    if (LDEN) mem[LDADDR] <= LDDATA;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      IDBUS <= '0;
      IRDY  <= 1'b0;
      IERR  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      IRDY <= 1'b0;
      IERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Preload wins the edge; a held request is picked up next edge.
          if (!IREQn && !LDEN) begin
            addr_q <= IADDR[AW+1:2];
            oor_q  <= |IADDR[31:AW+2];
            cnt    <= CW'(LATENCY);
            state  <= ST_WAIT;
            BUSY   <= 1'b1;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Nonblocking read sees the pre-edge array: read-before-write.
            IDBUS <= oor_q ? 32'h0 : mem[addr_q];
            IERR  <= oor_q;
            IRDY  <= 1'b1;
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
